// File: rtl/reset_sequencer_pkg.sv
// reset_seq_pkg: sequencer state type and counter width helper
// shared by the reset sequencer slice.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT,
    S_DONE,
    S_FAULT
  } seq_state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: per-stage reset release / ready bundle
// between the sequencer (master) and the released domains (slave).
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);

  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_resetn;

  modport master (
    input  stage_ack,
    output stage_resetn
  );

  modport slave (
    output stage_ack,
    input  stage_resetn
  );

endinterface

// File: rtl/reset_sequencer_lock_filter.sv
// lock_filter: qualifies pll_locked by requiring LOCK_FILTER
// consecutive high cycles; lock_ok pulses on the qualifying edge.
module lock_filter
  import reset_seq_pkg::*;
#(
  parameter int LOCK_FILTER = 8
) (
  input  logic clk,
  input  logic sync_resetn,
  input  logic clr,
  input  logic pll_locked,
  output logic lock_ok
);

  localparam int CW = clog2_min1(LOCK_FILTER);
  localparam logic [CW-1:0] LAST = CW'(LOCK_FILTER - 1);

  logic [CW-1:0] lock_cnt;

  assign lock_ok = pll_locked && !clr && (lock_cnt == LAST);

  // clearing on lock_ok keeps the counter from wrapping
  always_ff @(posedge clk) begin
    if (!sync_resetn || clr || !pll_locked || lock_ok) begin
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases downstream resets one by one after
// PLL lock, with inter-stage delay, ack wait and sticky timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int LOCK_FILTER  = 8,
  parameter int DELAY_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic                                clk,
  input  logic                                sync_resetn,
  input  logic                                pll_locked,
  reset_sequencer_if.master                   stg,
  output logic                                seq_done,
  output logic                                seq_fault,
  output logic [clog2_min1(NUM_STAGES)-1:0]   fault_stage
);

  localparam int IW = clog2_min1(NUM_STAGES);
  localparam int DW = clog2_min1(DELAY_CYCLES);
  localparam int TW = clog2_min1(ACK_TIMEOUT);
  localparam bit TO_EN = (ACK_TIMEOUT != 0);
  localparam int TO_MAX = TO_EN ? ACK_TIMEOUT - 1 : 0;

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_MAX);

  seq_state_t            state;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         dly_cnt;
  logic [TW-1:0]         to_cnt;
  logic [NUM_STAGES-1:0] rel_q;
  logic                  lock_ok;
  logic                  ack_cur;
  logic                  lock_lost;

  lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock (
    .clk        (clk),
    .sync_resetn(sync_resetn),
    .clr        (state != S_HOLD),
    .pll_locked (pll_locked),
    .lock_ok    (lock_ok)
  );

  assign ack_cur = stg.stage_ack[idx];
  assign stg.stage_resetn = rel_q;

  // S_HOLD handles its own lock drops; S_FAULT ignores lock
  assign lock_lost = !pll_locked &&
    (state == S_DELAY || state == S_WAIT || state == S_DONE);

  always_ff @(posedge clk) begin
    if (!sync_resetn) begin
      state       <= S_HOLD;
      idx         <= '0;
      dly_cnt     <= '0;
      to_cnt      <= '0;
      rel_q       <= '0;
      seq_done    <= 1'b0;
      seq_fault   <= 1'b0;
      fault_stage <= '0;
    end else if (lock_lost) begin
      state    <= S_HOLD;
      idx      <= '0;
      dly_cnt  <= '0;
      to_cnt   <= '0;
      rel_q    <= '0;
      seq_done <= 1'b0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (lock_ok) begin
            state   <= S_DELAY;
            idx     <= '0;
            dly_cnt <= '0;
          end
        end
        S_DELAY: begin
          if (dly_cnt == DLY_LAST) begin
            rel_q[idx] <= 1'b1;
            state      <= S_WAIT;
            to_cnt     <= '0;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (ack_cur) begin
            if (idx == IDX_LAST) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
            end else begin
              idx     <= idx + 1'b1;
              dly_cnt <= '0;
              state   <= S_DELAY;
            end
          end else if (TO_EN && to_cnt == TO_LAST) begin
            state       <= S_FAULT;
            seq_fault   <= 1'b1;
            fault_stage <= idx;
            rel_q       <= '0;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          seq_done <= 1'b1;
        end
        S_FAULT: begin
          rel_q    <= '0;
          seq_done <= 1'b0;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized scenarios checked against an
// event-level model of lock qualification, delays, acks and timeout.
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int LF  = 8;
  localparam int DLY = 16;

  logic       clk = 1'b0;
  logic       sync_resetn;
  logic       pll_locked;
  logic       done_a, fault_a, done_b, fault_b;
  logic [1:0] fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  reset_sequencer_if #(.NUM_STAGES(N)) ifa ();
  reset_sequencer_if #(.NUM_STAGES(N)) ifb ();

  reset_sequencer #(
    .NUM_STAGES(N), .LOCK_FILTER(LF),
    .DELAY_CYCLES(DLY), .ACK_TIMEOUT(32)
  ) u_a (
    .clk(clk), .sync_resetn(sync_resetn), .pll_locked(pll_locked),
    .stg(ifa), .seq_done(done_a), .seq_fault(fault_a),
    .fault_stage(fs_a)
  );

  reset_sequencer #(
    .NUM_STAGES(N), .LOCK_FILTER(LF),
    .DELAY_CYCLES(DLY), .ACK_TIMEOUT(0)
  ) u_b (
    .clk(clk), .sync_resetn(sync_resetn), .pll_locked(pll_locked),
    .stg(ifb), .seq_done(done_b), .seq_fault(fault_b),
    .fault_stage(fs_b)
  );

  always #5 clk = ~clk;

  // model: lock run length, released count, delay countdown, wait time
  int m_run[2], m_rel[2], m_cd[2], m_wt[2], m_fs[2];
  bit m_idle[2], m_done[2], m_flt[2];

  // loopback stimulus for u_a
  int         seen[N];
  int         dly[N];
  logic [N-1:0] mask, frc;

  function automatic void model_edge(input int i, input int to,
    input bit rst, input bit lock, input logic [N-1:0] ack);
    if (!rst) begin
      m_run[i] = 0; m_rel[i] = 0; m_cd[i] = 0; m_wt[i] = 0;
      m_fs[i] = 0; m_idle[i] = 1; m_done[i] = 0; m_flt[i] = 0;
    end else if (m_flt[i]) begin
      m_rel[i] = 0;
    end else if (m_idle[i]) begin
      m_run[i] = lock ? m_run[i] + 1 : 0;
      if (m_run[i] == LF) begin
        m_idle[i] = 0; m_run[i] = 0; m_cd[i] = DLY;
      end
    end else if (!lock) begin
      m_idle[i] = 1; m_rel[i] = 0; m_done[i] = 0; m_run[i] = 0;
    end else if (m_done[i]) begin
      m_done[i] = 1;
    end else if (m_cd[i] > 0) begin
      m_cd[i]--;
      if (m_cd[i] == 0) begin m_rel[i]++; m_wt[i] = 0; end
    end else if (ack[m_rel[i]-1] === 1'b1) begin
      if (m_rel[i] == N) m_done[i] = 1;
      else m_cd[i] = DLY;
    end else begin
      m_wt[i]++;
      if (to != 0 && m_wt[i] == to) begin
        m_flt[i] = 1; m_fs[i] = m_rel[i] - 1; m_rel[i] = 0;
      end
    end
  endfunction

  function automatic logic [7:0] exp_vec(input int i);
    logic [3:0] r;
    r = 4'((1 << m_rel[i]) - 1);
    return {r, m_done[i], m_flt[i], 2'(m_fs[i])};
  endfunction

  function automatic logic [7:0] dut_vec(input int i);
    if (i == 0) return {ifa.stage_resetn, done_a, fault_a, fs_a};
    return {ifb.stage_resetn, done_b, fault_b, fs_b};
  endfunction

  task automatic loop_ack();
    for (int k = 0; k < N; k++) begin
      seen[k] = (ifa.stage_resetn[k] === 1'b1) ? seen[k] + 1 : 0;
      ifa.stage_ack[k] = frc[k] | (mask[k] & (seen[k] >= dly[k]));
    end
  endtask

  task automatic tick();
    model_edge(0, 32, sync_resetn, pll_locked, ifa.stage_ack);
    model_edge(1, 0, sync_resetn, pll_locked, ifb.stage_ack);
    @(negedge clk);
    loop_ack();
  endtask

  task automatic do_reset();
    sync_resetn = 1'b0;
    repeat (2) tick();
    sync_resetn = 1'b1;
  endtask

  task automatic test_reset();
    sync_resetn = 1'b0; pll_locked = 1'b1;
    mask = '0; frc = '0;
    ifb.stage_ack = '0;
    loop_ack();
    repeat (3) tick();
    checks++;
    if (dut_vec(0) !== 8'h00) begin
      errors++;
      $display("FAIL reset_a got=%h exp=00", dut_vec(0));
    end
    checks++;
    if (dut_vec(1) !== 8'h00) begin
      errors++;
      $display("FAIL reset_b got=%h exp=00", dut_vec(1));
    end
    checks++;
    if (dut_vec(0) !== exp_vec(0)) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_latency();
    int rt[N];
    int dt;
    mask = '1; frc = '0;
    for (int k = 0; k < N; k++) begin dly[k] = 3; rt[k] = -1; end
    pll_locked = 1'b1;
    do_reset();
    dt = -1;
    for (int t = 1; t <= 300 && dt < 0; t++) begin
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL lat_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
      for (int k = 0; k < N; k++)
        if (rt[k] < 0 && ifa.stage_resetn[k] === 1'b1) rt[k] = t;
      if (done_a === 1'b1) dt = t;
    end
    checks++;
    if (rt[0] != LF + DLY) begin
      errors++;
      $display("FAIL lat_first got=%0d exp=%0d", rt[0], LF + DLY);
    end
    for (int k = 0; k < N - 1; k++) begin
      checks++;
      if (rt[k+1] - rt[k] != DLY + 3) begin
        errors++;
        $display("FAIL lat_gap k=%0d got=%0d exp=%0d", k, rt[k+1] - rt[k], DLY + 3);
      end
    end
    checks++;
    if (dt < 0 || dt - rt[N-1] != 3) begin
      errors++;
      $display("FAIL lat_done got=%0d exp=3", dt - rt[N-1]);
    end
  endtask

  task automatic test_lock_filter();
    int r0;
    mask = '1; frc = '0;
    for (int k = 0; k < N; k++) dly[k] = 3;
    pll_locked = 1'b0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      pll_locked = (t % 5) != 4;
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL glitch_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
    end
    checks++;
    if (ifa.stage_resetn !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_hold got=%b exp=0000", ifa.stage_resetn);
    end
    pll_locked = 1'b1;
    r0 = -1;
    for (int t = 1; t <= 100 && r0 < 0; t++) begin
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL stable_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
      if (ifa.stage_resetn[0] === 1'b1) r0 = t;
    end
    checks++;
    if (r0 != LF + DLY) begin
      errors++;
      $display("FAIL stable_first got=%0d exp=%0d", r0, LF + DLY);
    end
  endtask

  task automatic test_timeout();
    int r2, ft;
    mask = 4'b1011; frc = '0;
    for (int k = 0; k < N; k++) dly[k] = 3;
    pll_locked = 1'b1;
    do_reset();
    r2 = -1; ft = -1;
    for (int t = 1; t <= 400 && ft < 0; t++) begin
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL to_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
      if (r2 < 0 && ifa.stage_resetn[2] === 1'b1) r2 = t;
      if (fault_a === 1'b1) ft = t;
    end
    checks++;
    if (r2 < 0 || ft < 0 || ft - r2 != 32) begin
      errors++;
      $display("FAIL to_latency got=%0d exp=32", ft - r2);
    end
    checks++;
    if (dut_vec(0) !== 8'h06) begin
      errors++;
      $display("FAIL to_state got=%h exp=06", dut_vec(0));
    end
    for (int t = 0; t < 30; t++) begin
      pll_locked = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL to_sticky t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
    end
    pll_locked = 1'b1;
    sync_resetn = 1'b0;
    tick();
    sync_resetn = 1'b1;
    checks++;
    if (dut_vec(0) !== 8'h00) begin
      errors++;
      $display("FAIL to_clear got=%h exp=00", dut_vec(0));
    end
  endtask

  task automatic test_lock_loss();
    int ph;
    mask = '1; frc = '0;
    for (int k = 0; k < N; k++) dly[k] = 3;
    pll_locked = 1'b1;
    do_reset();
    ph = 0;
    for (int t = 1; t <= 400 && ph < 5; t++) begin
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL loss_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
      if (ph == 1 || ph == 3) begin
        checks++;
        if (dut_vec(0) !== 8'h00) begin
          errors++;
          $display("FAIL loss_drop ph=%0d got=%h exp=00", ph, dut_vec(0));
        end
        pll_locked = 1'b1;
        ph++;
      end else if (ph == 0 && ifa.stage_resetn[1] === 1'b1) begin
        pll_locked = 1'b0; ph = 1;
      end else if (ph == 2 && done_a === 1'b1) begin
        pll_locked = 1'b0; ph = 3;
      end else if (ph == 4 && done_a === 1'b1) begin
        ph = 5;
      end
    end
    checks++;
    if (ph != 5) begin
      errors++;
      $display("FAIL loss_resequence got=%0d exp=5", ph);
    end
  endtask

  task automatic test_preack();
    int rt[N];
    int dt;
    mask = 4'b0001; frc = 4'b1110;
    dly[0] = $urandom_range(1, 6);
    for (int k = 0; k < N; k++) rt[k] = -1;
    pll_locked = 1'b1;
    do_reset();
    dt = -1;
    for (int t = 1; t <= 300 && dt < 0; t++) begin
      tick();
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL pre_seq t=%0d got=%h exp=%h", t, dut_vec(0), exp_vec(0));
      end
      for (int k = 0; k < N; k++)
        if (rt[k] < 0 && ifa.stage_resetn[k] === 1'b1) rt[k] = t;
      if (done_a === 1'b1) dt = t;
    end
    checks++;
    if (rt[1] - rt[0] != dly[0] + DLY) begin
      errors++;
      $display("FAIL pre_gap0 got=%0d exp=%0d", rt[1] - rt[0], dly[0] + DLY);
    end
    for (int k = 1; k < N - 1; k++) begin
      checks++;
      if (rt[k+1] - rt[k] != DLY + 1) begin
        errors++;
        $display("FAIL pre_gap k=%0d got=%0d exp=%0d", k, rt[k+1] - rt[k], DLY + 1);
      end
    end
    checks++;
    if (dt < 0 || dt - rt[N-1] != 1) begin
      errors++;
      $display("FAIL pre_done got=%0d exp=1", dt - rt[N-1]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) dly[k] = $urandom_range(1, 8);
      mask = '1; frc = '0;
      if ($urandom_range(0, 2) == 0) mask[$urandom_range(0, N-1)] = 1'b0;
      pll_locked = 1'b1;
      do_reset();
      for (int t = 1; t <= 300; t++) begin
        pll_locked = ($urandom_range(0, 59) != 0);
        tick();
        checks++;
        if (dut_vec(0) !== exp_vec(0)) begin
          errors++;
          $display("FAIL rand_seq r=%0d t=%0d got=%h exp=%h", r, t, dut_vec(0), exp_vec(0));
        end
      end
    end
  endtask

  task automatic test_no_timeout();
    int r0;
    ifb.stage_ack = '0;
    mask = 4'b1110; frc = '0;
    for (int k = 0; k < N; k++) dly[k] = 3;
    pll_locked = 1'b1;
    do_reset();
    r0 = -1;
    for (int t = 1; t <= 5030; t++) begin
      tick();
      checks++;
      if (dut_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL nto_seq t=%0d got=%h exp=%h", t, dut_vec(1), exp_vec(1));
      end
      if (r0 < 0 && ifa.stage_resetn[0] === 1'b1) r0 = t;
      if (t == r0 + 31) begin
        frc[0] = 1'b1;
        loop_ack();
      end
      if (r0 > 0 && t == r0 + 32) begin
        checks++;
        if (fault_a !== 1'b0 || exp_vec(0) !== dut_vec(0)) begin
          errors++;
          $display("FAIL ack_boundary got=%h exp=%h", dut_vec(0), exp_vec(0));
        end
      end
    end
    checks++;
    if (fault_b !== 1'b0 || ifb.stage_resetn !== 4'b0001) begin
      errors++;
      $display("FAIL nto_hold got=%b/%b exp=0/0001", fault_b, ifb.stage_resetn);
    end
    checks++;
    if (done_a !== 1'b1 || fault_a !== 1'b0) begin
      errors++;
      $display("FAIL ack_boundary_done got=%b/%b exp=1/0", done_a, fault_a);
    end
    ifb.stage_ack = 4'b0001;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (dut_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL nto_ack t=%0d got=%h exp=%h", t, dut_vec(1), exp_vec(1));
      end
    end
  endtask

  initial begin
    sync_resetn = 1'b0;
    pll_locked  = 1'b0;
    mask = '0;
    frc  = '0;
    for (int k = 0; k < N; k++) begin seen[k] = 0; dly[k] = 3; end
    ifa.stage_ack = '0;
    ifb.stage_ack = '0;
    test_reset();
    test_latency();
    test_lock_filter();
    test_timeout();
    test_lock_loss();
    test_preack();
    test_random();
    test_no_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
